// File: rtl/aes_round_core.sv
// aes_round_core -- iterative AES-128 encryption core, one round per clock.
// Sits directly downstream of keyExpan: drives its round index, consumes its round key.
// Build option: define AES_KEYREG_EN to register round_key before use. That adds a
// PREFETCH state, round_idx then runs one round ahead of the datapath, and latency
// grows from 11 to 12 cycles. Ciphertext is identical in both builds.

module aes_sub_bytes (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] lookup(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  // One table lookup per byte of the column.
  assign o_word = {lookup(i_word[31:24]), lookup(i_word[23:16]),
                   lookup(i_word[15:8]),  lookup(i_word[7:0])};

endmodule

module aes_round_core #(
  parameter int          NR     = 10,
  parameter logic [127:0] RST_CT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic         key_ready,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam logic [3:0] LAST_MID  = 4'(NR - 1);
  localparam logic [3:0] FINAL_IDX = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_LOAD, S_ROUND, S_FINAL, S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_st;
  logic [3:0]   r_roundCnt;
  logic [127:0] r_ct;
  logic [127:0] w_key;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the block sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_col
    aes_sub_bytes u_sub (
      .i_word (r_st[127-32*g -: 32]),
      .o_word (w_sb[127-32*g -: 32])
    );
  end

  assign w_sr = shiftRows(w_sb);
  assign w_mc = mixColumns(w_sr);

`ifdef AES_KEYREG_EN
  logic [127:0] r_key;

  // Capture the key for the next datapath step; a stall freezes it along with the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= '0;
    end else if (key_ready && (r_state inside {S_PREFETCH, S_LOAD, S_ROUND})) begin
      r_key <= round_key;
    end
  end

  assign w_key = r_key;
`else
  assign w_key = round_key;
`endif

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; round_idx stays 0 whenever the key is unused.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    round_idx   = 4'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef AES_KEYREG_EN
          w_nextState = S_PREFETCH;
`else
          w_nextState = S_LOAD;
`endif
        end
      end
`ifdef AES_KEYREG_EN
      S_PREFETCH: begin
        busy      = 1'b1;
        round_idx = 4'd0;
        if (key_ready) w_nextState = S_LOAD;
      end
`endif
      S_LOAD: begin
        busy = 1'b1;
`ifdef AES_KEYREG_EN
        round_idx = 4'd1;
`else
        round_idx = 4'd0;
`endif
        if (key_ready) w_nextState = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
`ifdef AES_KEYREG_EN
        round_idx = r_roundCnt + 4'd1;
`else
        round_idx = r_roundCnt;
`endif
        if (key_ready && (r_roundCnt == LAST_MID)) w_nextState = S_FINAL;
      end
      S_FINAL: begin
        busy = 1'b1;
`ifdef AES_KEYREG_EN
        round_idx = 4'd0;
`else
        round_idx = FINAL_IDX;
`endif
        if (key_ready) w_nextState = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Block state and round counter; nothing moves while key_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= '0;
      r_roundCnt <= 4'd0;
      r_ct       <= RST_CT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st       <= plaintext;
            r_roundCnt <= 4'd0;
          end
        end
        S_LOAD: begin
          if (key_ready) begin
            r_st       <= r_st ^ w_key;
            r_roundCnt <= 4'd1;
          end
        end
        S_ROUND: begin
          if (key_ready) begin
            r_st <= w_mc ^ w_key;
            if (r_roundCnt != LAST_MID) r_roundCnt <= r_roundCnt + 4'd1;
          end
        end
        S_FINAL: begin
          if (key_ready) r_ct <= w_sr ^ w_key;
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes_round_core.sv
// tb_aes_round_core -- directed bench for aes_round_core with a behavioural AES model.
// A bench-side key schedule plays the role of keyExpan, serving round_key from round_idx.

module tb_aes_round_core;

  localparam int LAT =
`ifdef AES_KEYREG_EN
    12;
`else
    11;
`endif

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         key_ready;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  logic [127:0] rk [16];
  logic [7:0]   sboxTab [256];
  logic [127:0] curKey;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state: phase, productive cycles used, expected outputs.
  int           mPhase = PH_IDLE;
  int           mProg = 0;
  bit           mArmed = 0;
  logic [127:0] mCt = '0;
  logic [127:0] mPending = '0;
  int           acceptCyc [$];
  int           doneCyc [$];
  bit           recIdx = 0;
  logic [3:0]   idxQ [$];

  aes_round_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_ready  (key_ready),
    .round_idx  (round_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  assign round_key = rk[round_idx];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference AES, written straight from the algorithm ----------------
  function automatic logic [7:0] gmulM(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x};
    return d[15-k -: 8];
  endfunction

  function automatic logic [7:0] sboxCalc(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmulM(inv, b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWordM(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  function automatic logic [127:0] roundKeyM(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = subWordM({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmulM(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aesModel(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] o;
    k = roundKeyM(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sboxTab[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = gmulM(t[4*c], 8'h02) ^ gmulM(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmulM(t[4*c+1], 8'h02) ^ gmulM(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmulM(t[4*c+2], 8'h02) ^ gmulM(t[4*c+3], 8'h03);
          s[4*c+3] = gmulM(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmulM(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      k = roundKeyM(key, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic setKey(input logic [127:0] key);
    curKey = key;
    for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? roundKeyM(key, r) : 'x;
  endtask

  task automatic waitCount(input string name, input bit useDone, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if ((useDone ? doneCyc.size() : acceptCyc.size()) >= target) break;
      @(negedge clk);
    end
    checkOutput(name, 128'((useDone ? doneCyc.size() : acceptCyc.size()) >= target), 128'(1));
  endtask

  task automatic applyStimulus(input logic [127:0] pt);
    int target;
    target    = acceptCyc.size() + 1;
    plaintext = pt;
    in_valid  = 1'b1;
    waitCount("accept_wait", 1'b0, target, 20);
    in_valid  = 1'b0;
  endtask

  task automatic waitDone(input string name);
    waitCount(name, 1'b1, doneCyc.size() + 1, 60);
  endtask

  // Model: an accepted block needs LAT cycles with key_ready high, then waits for out_ready.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mPhase = PH_IDLE;
        mProg  = 0;
        mCt    = '0;
        mArmed = 1'b1;
      end else if (mArmed) begin
        case (mPhase)
          PH_IDLE: if (in_valid) begin
            mPhase   = PH_RUN;
            mProg    = 0;
            mPending = aesModel(curKey, plaintext);
            acceptCyc.push_back(cyc);
          end
          PH_RUN: if (key_ready) begin
            if (mProg == LAT - 1) begin
              mPhase = PH_DONE;
              mCt    = mPending;
              doneCyc.push_back(cyc);
            end else begin
              mProg++;
            end
          end
          default: if (out_ready) mPhase = PH_IDLE;
        endcase
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mArmed) begin
        checkOutput("in_ready",   128'(in_ready),  128'(mPhase == PH_IDLE));
        checkOutput("busy",       128'(busy),      128'(mPhase == PH_RUN));
        checkOutput("out_valid",  128'(out_valid), 128'(mPhase == PH_DONE));
        checkOutput("ciphertext", ciphertext,      mCt);
        checkOutput("round_idx",  128'(round_idx),
                    128'((mPhase == PH_RUN && mProg <= 10) ? mProg : 0));
        if (recIdx && busy && key_ready) idxQ.push_back(round_idx);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int target;
    logic [127:0] got [3];

    for (int i = 0; i < 256; i++) sboxTab[i] = sboxCalc(8'(i));

    rst = 1'b1; in_valid = 1'b0; plaintext = '0; key_ready = 1'b0; out_ready = 1'b0;
    setKey(KEY1);
    repeat (3) @(negedge clk);

    // Reset state and model pins.
    checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
    checkOutput("rst_busy",      128'(busy),      128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_ct",        ciphertext,      128'h0);
    checkOutput("rst_round_idx", 128'(round_idx), 128'(0));
    checkOutput("sbox_00", 128'(sboxTab[8'h00]), 128'h63);
    checkOutput("sbox_53", 128'(sboxTab[8'h53]), 128'hed);
    checkOutput("sbox_ff", 128'(sboxTab[8'hff]), 128'h16);
    checkOutput("model_T1", aesModel(KEY1, PT1), CT1);
    checkOutput("model_T2", aesModel(KEY2, PT2), CT2);
    rst = 1'b0; key_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] T1 FIPS-197 App.B vector");
    applyStimulus(PT1);
    waitDone("T1_wait");
    checkOutput("T1_ct", ciphertext, CT1);
    checkOutput("T1_latency", 128'(doneCyc[$] - acceptCyc[$]), 128'(LAT));
    @(negedge clk);

    $display("[TB] T2 FIPS-197 App.C.1 vector and round_idx sequence");
    setKey(KEY2);
    idxQ.delete();
    recIdx = 1'b1;
    applyStimulus(PT2);
    waitDone("T2_wait");
    recIdx = 1'b0;
    checkOutput("T2_ct", ciphertext, CT2);
    checkOutput("T2_idx_count", 128'(idxQ.size()), 128'(LAT));
    for (int i = 0; i <= 10 && i < idxQ.size(); i++)
      checkOutput($sformatf("T2_idx_%0d", i), 128'(idxQ[i]), 128'(i));
    @(negedge clk);

    $display("[TB] T3 key_ready stall during round 5");
    setKey(KEY1);
    applyStimulus(PT1);
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) @(negedge clk);
    checkOutput("T3_reach", 128'(round_idx), 128'(5));
    key_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("T3_idx_hold", 128'(round_idx), 128'(5));
    end
    key_ready = 1'b1;
    waitDone("T3_wait");
    checkOutput("T3_ct", ciphertext, CT1);
    checkOutput("T3_latency", 128'(doneCyc[$] - acceptCyc[$]), 128'(LAT + 3));
    @(negedge clk);

    $display("[TB] T4 output back-pressure with ignored input offers");
    setKey(KEY2);
    out_ready = 1'b0;
    applyStimulus(PT2);
    waitDone("T4_wait");
    target = acceptCyc.size();
    plaintext = PT1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      checkOutput("T4_out_valid", 128'(out_valid), 128'(1));
      checkOutput("T4_ct", ciphertext, CT2);
      checkOutput("T4_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("T4_no_turnaround", 128'(acceptCyc.size()), 128'(target));
    checkOutput("T4_back_idle", 128'(in_ready), 128'(1));
    @(negedge clk);

    $display("[TB] T5 reset during round 4, then clean run");
    setKey(KEY1);
    applyStimulus(PT1);
    for (int i = 0; i < 20 && round_idx != 4'd4; i++) @(negedge clk);
    checkOutput("T5_reach", 128'(round_idx), 128'(4));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("T5_out_valid", 128'(out_valid), 128'(0));
    checkOutput("T5_busy",      128'(busy),      128'(0));
    checkOutput("T5_ct",        ciphertext,      128'h0);
    checkOutput("T5_in_ready",  128'(in_ready),  128'(1));
    rst = 1'b0;
    setKey(KEY2);
    @(negedge clk);
    applyStimulus(PT2);
    waitDone("T5_wait");
    checkOutput("T5_clean_ct", ciphertext, CT2);
    @(negedge clk);

    $display("[TB] T6 back-to-back blocks");
    setKey(KEY1);
    target = acceptCyc.size();
    plaintext = PT1;
    in_valid  = 1'b1;
    waitCount("T6_acc1", 1'b0, target + 1, 20);
    plaintext = PT2;
    waitCount("T6_done1", 1'b1, doneCyc.size() + 1, 40);
    got[0] = ciphertext;
    setKey(KEY2);
    waitCount("T6_acc2", 1'b0, target + 2, 20);
    plaintext = PT1;
    waitCount("T6_done2", 1'b1, doneCyc.size() + 1, 40);
    got[1] = ciphertext;
    setKey(KEY1);
    waitCount("T6_acc3", 1'b0, target + 3, 20);
    in_valid = 1'b0;
    waitCount("T6_done3", 1'b1, doneCyc.size() + 1, 40);
    got[2] = ciphertext;
    checkOutput("T6_ct0", got[0], CT1);
    checkOutput("T6_ct1", got[1], CT2);
    checkOutput("T6_ct2", got[2], CT1);
    // Each block spends one cycle in IDLE and one in DONE around the datapath latency.
    checkOutput("T6_space_a", 128'(acceptCyc[$] - acceptCyc[$-1]), 128'(LAT + 2));
    checkOutput("T6_space_b", 128'(acceptCyc[$-1] - acceptCyc[$-2]), 128'(LAT + 2));
    checkOutput("T6_space_d", 128'(doneCyc[$] - doneCyc[$-1]), 128'(LAT + 2));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
